// File: rtl/seq_mul_add_pkg.sv
// Shared definitions for the sequential multiply-accumulate unit.
package seq_mul_add_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_C,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/seq_mul_add_datapath.sv
// Operand registers, shift-and-add accumulator, iteration counter and result register.
module seq_mul_add_datapath
    import seq_mul_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               ldA,
    input  logic               ldB,
    input  logic               ldC,
    input  logic               shift_add,
    input  logic               ld_result,
    output logic               last_iter,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [2*WIDTH-1:0] m_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] sum;

    // Next accumulator value; also the final product on the last iteration.
    always_comb begin
        sum = p_reg + (q_reg[0] ? m_reg : '0);
    end

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // C is consumed directly into the accumulator, so it needs no register of its own.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            q_reg  <= '0;
            m_reg  <= '0;
            p_reg  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (ldA) a_reg <= data_in;
            if (ldB) b_reg <= data_in;
            if (ldC) begin
                p_reg <= {{WIDTH{1'b0}}, data_in};
                m_reg <= {{WIDTH{1'b0}}, a_reg};
                q_reg <= b_reg;
                cnt   <= '0;
            end else if (shift_add) begin
                p_reg <= sum;
                m_reg <= m_reg << 1;
                q_reg <= q_reg >> 1;
                cnt   <= cnt + 1'b1;
            end
            if (ld_result) result <= sum;
        end
    end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential multiply-accumulate: result = A*B + C, operands loaded over data_in on three edges.
module seq_mul_add
    import seq_mul_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);

    state_t state, state_next;
    logic   ldA, ldB, ldC, shift_add, ld_result;
    logic   last_iter;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        ldA        = 1'b0;
        ldB        = 1'b0;
        ldC        = 1'b0;
        shift_add  = 1'b0;
        ld_result  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ldA        = 1'b1;
                    state_next = LOAD_B;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD_B: begin
                ldB        = 1'b1;
                state_next = LOAD_C;
            end
            LOAD_C: begin
                ldC        = 1'b1;
                state_next = MUL;
            end
            MUL: begin
                shift_add = 1'b1;
                if (last_iter) begin
                    ld_result  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decoded from the state register, so both clear asynchronously with reset.
    assign busy = (state == LOAD_B) || (state == LOAD_C) || (state == MUL);
    assign done = (state == DONE);

    seq_mul_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .ldA       (ldA),
        .ldB       (ldB),
        .ldC       (ldC),
        .shift_add (shift_add),
        .ld_result (ld_result),
        .last_iter (last_iter),
        .result    (result)
    );

endmodule
